expr_sched: RTL
===============

EXPR_SCHED -- requirements
Module: expr_sched

Interface
REQ-001 Parameter LATENCY, default 56, cycles from launching an operand on dp_x to dp_result being valid.
REQ-002 Parameter W, default 32, operand/result width (IEEE-754 single).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  2  per-requester operand valid (bit i = requester i).
REQ-006 in_x0  input  W  operand from requester 0.
REQ-007 in_x1  input  W  operand from requester 1.
REQ-008 in_ready  output  2  per-requester accept; handshake when in_valid[i] & in_ready[i] at a posedge.
REQ-009 dp_x  output  W  registered operand driven to the shared expr datapath x input.
REQ-010 dp_result  input  W  result from the shared expr datapath.
REQ-011 res_valid  output  1  result available.
REQ-012 res_data  output  W  captured result.
REQ-013 res_id  output  1  requester index that owns res_data.
REQ-014 res_ready  input  1  consumer accepts result when res_valid & res_ready at a posedge.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, RUN, DONE; the datapath is non-pipelined, so at most one operation is in flight.
REQ-017 in_ready is combinational: in_ready[i] = (state==IDLE) & grant==i & in_valid[i]; in_ready is all-zero outside IDLE.
REQ-018 Arbitration round-robin on a 1-bit last_grant: only one valid -> grant it; both valid -> grant the requester != last_grant.
REQ-019 On handshake at edge T: dp_x <= selected operand, owner id latched, last_grant <= granted index, counter <= 0, state <= RUN.
REQ-020 dp_x holds its value unchanged from edge T until the next handshake (the datapath reads x at several stages).
REQ-021 In RUN the counter increments each cycle; at edge T+LATENCY: res_data <= dp_result, res_id <= owner, res_valid <= 1, state <= DONE.
REQ-022 Counter width is clog2(LATENCY+1); it never wraps (terminal value ends RUN).
REQ-023 In DONE, res_data/res_id/res_valid hold stable until res_ready; on res_valid & res_ready: res_valid <= 0, state <= IDLE.
REQ-024 No new operand is accepted in the DONE cycle where the result is consumed; earliest next handshake is the following cycle (one-cycle bubble).
REQ-025 res_ready while res_valid=0 has no effect; in_valid changes during RUN/DONE have no effect and are not queued.
REQ-026 dp_result is ignored at all cycles other than edge T+LATENCY.
REQ-027 Handshake-to-res_valid latency is exactly LATENCY cycles; throughput at most one result per LATENCY+2 cycles.

Reset
REQ-028 reset asserted: state <= IDLE, counter <= 0, dp_x <= 0, res_data <= 0, res_id <= 0, res_valid <= 0, last_grant <= 1 (requester 0 wins first tie), immediately and independent of clk.
REQ-029 Reset mid-RUN or mid-DONE aborts the operation; its result is never presented; the first post-reset handshake runs the full LATENCY.
REQ-030 With reset high, in_ready = 0 and busy = 0.

Verification
REQ-031 Single op: datapath stub returns 0x40800000 at T+56; in_valid=01, in_x0=0x40000000 -> in_ready=01 same cycle, dp_x=0x40000000 after T, res_valid at edge T+56 with res_data=0x40800000, res_id=0.
REQ-032 Tie after reset: in_valid=11 held -> grants 0,1,0,1 for four consecutive ops, res_id matches, dp_x matches respective operand.
REQ-033 Backpressure: res_ready low 10 cycles after res_valid -> res_data/res_id stable, in_ready=00 throughout; raise res_ready -> res_valid low next edge, next handshake one cycle later.
REQ-034 Reset mid-op: assert reset at T+20 -> all outputs zero asynchronously, no res_valid; new request afterwards -> res_valid at exactly T'+56.
REQ-035 dp_result stability: stub drives garbage at all cycles except T+56 -> res_data equals only the T+56 value; dp_x constant across all 56 cycles.
REQ-036 LATENCY=3 build: single op -> res_valid at edge T+3, counter never exceeds 3.

Source files
------------

// File: rtl/expr_sched.sv
// Scheduler that shares one non-pipelined expr datapath between two requesters.
// Round-robin arbitration, fixed-latency capture, result held until consumed.
module expr_sched #(
    parameter int LATENCY = 56,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   in_valid,
    input  logic [W-1:0] in_x0,
    input  logic [W-1:0] in_x1,
    output logic [1:0]   in_ready,
    output logic [W-1:0] dp_x,
    input  logic [W-1:0] dp_result,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_id,
    input  logic         res_ready,
    output logic         busy
);

    localparam int            CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   dp_x_q, dp_x_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           res_id_q, res_id_d;
    logic           res_valid_q, res_valid_d;
    logic           last_grant_q, last_grant_d;
    logic           grant_idx;
    logic [1:0]     in_ready_c;

    // Handshakes: a transfer happens at a posedge where valid & ready are both
    // high; ready never depends on anything but state, last_grant and valid.
    always_comb begin
        grant_idx  = (&in_valid) ? ~last_grant_q : in_valid[1];
        in_ready_c = '0;
        if (state_q == IDLE && !reset) begin
            in_ready_c[grant_idx] = in_valid[grant_idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dp_x_d       = dp_x_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        res_valid_d  = res_valid_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|in_ready_c) begin
                    dp_x_d       = grant_idx ? in_x1 : in_x0;
                    last_grant_d = grant_idx;
                    cnt_d        = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                // last_grant only moves on a handshake, so it still names the owner here
                if (cnt_q == LAST_CNT) begin
                    res_data_d  = dp_result;
                    res_id_d    = last_grant_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dp_x_q       <= '0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dp_x_q       <= dp_x_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            res_valid_q  <= res_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign dp_x      = dp_x_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule
